// File: rtl/bp_update_sched_pkg.sv
// Shared types and helpers for the branch pattern history table update scheduler.
// Holds the FSM state encoding, the 2-bit counter type and the saturating-counter step.
package bp_update_sched_pkg;

   typedef enum logic [1:0] {
      INIT  = 2'b00,
      IDLE  = 2'b01,
      READ  = 2'b10,
      WRITE = 2'b11
   } bp_state_t;

   typedef logic [1:0] pht_cnt_t;

   localparam pht_cnt_t    PHT_INIT = 2'b01;
   localparam logic [15:0] PC_STEP  = 16'h0002;

   // Two-bit saturating counter: taken moves toward 11, not-taken toward 00.
   function automatic pht_cnt_t sat_next(input pht_cnt_t cnt, input logic taken);
      if (taken) begin
         return (cnt == 2'b11) ? cnt : cnt + 2'b01;
      end
      return (cnt == 2'b00) ? cnt : cnt - 2'b01;
   endfunction

endpackage

// File: rtl/bp_update_sched_if.sv
// WB-side, PHT update-port and status signals of the PHT update scheduler.
// The stats counters exist only when BP_STATS_EN is defined.
interface bp_update_sched_if #(
   parameter int IDX_W = 8
);
   import bp_update_sched_pkg::*;

   logic             wb_valid;
   logic [15:0]      wb_pcplus2;
   logic             wb_taken;
   logic             wb_pred_taken;
   logic             flush_req;
   logic [IDX_W-1:0] pht_rd_index;
   pht_cnt_t         pht_rd_data;
   logic             pht_we;
   logic [IDX_W-1:0] pht_wr_index;
   pht_cnt_t         pht_wr_data;
   logic             init_busy;
   logic             q_full;
   logic             q_overflow;
`ifdef BP_STATS_EN
   logic [31:0]      stat_branches;
   logic [31:0]      stat_mispredicts;

   modport slave (
      input  wb_valid, wb_pcplus2, wb_taken, wb_pred_taken, flush_req, pht_rd_data,
      output pht_rd_index, pht_we, pht_wr_index, pht_wr_data,
      output init_busy, q_full, q_overflow, stat_branches, stat_mispredicts
   );
   modport master (
      output wb_valid, wb_pcplus2, wb_taken, wb_pred_taken, flush_req, pht_rd_data,
      input  pht_rd_index, pht_we, pht_wr_index, pht_wr_data,
      input  init_busy, q_full, q_overflow, stat_branches, stat_mispredicts
   );
`else
   modport slave (
      input  wb_valid, wb_pcplus2, wb_taken, wb_pred_taken, flush_req, pht_rd_data,
      output pht_rd_index, pht_we, pht_wr_index, pht_wr_data,
      output init_busy, q_full, q_overflow
   );
   modport master (
      output wb_valid, wb_pcplus2, wb_taken, wb_pred_taken, flush_req, pht_rd_data,
      input  pht_rd_index, pht_we, pht_wr_index, pht_wr_data,
      input  init_busy, q_full, q_overflow
   );
`endif

endinterface

// File: rtl/bp_update_sched_fifo.sv
// Small synchronous FIFO of pending PHT updates {index, taken}.
// A pop and a push in the same cycle are both honoured even when full.
module bp_update_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int            PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_FULL);
   assign head    = mem_q[rd_ptr_q];
   assign do_pop  = pop && !empty && !clear;
   assign do_push = push && (!full || do_pop) && !clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/bp_update_sched.sv
// Serializes all writes into the PHT: init/flush sweep plus buffered WB read-modify-write updates.
// Optional branch/mispredict counters are compiled in with BP_STATS_EN.
module bp_update_sched
   import bp_update_sched_pkg::*;
#(
   parameter int       DEPTH      = 4,
   parameter int       IDX_W      = 8,
   parameter pht_cnt_t INIT_STATE = PHT_INIT
) (
   input logic              clk,
   input logic              reset,
   bp_update_sched_if.slave bus
);
   localparam logic [IDX_W-1:0] LAST_IDX  = '1;
   localparam logic [IDX_W-1:0] SWEEP_ONE = IDX_W'(1);

   bp_state_t        state_q, state_d;
   logic [IDX_W-1:0] sweep_q, sweep_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   pht_cnt_t         wr_data_q, wr_data_d;
   logic             we_q, we_d;
   logic             busy_q, busy_d;
   logic             ovf_q, ovf_d;

   logic [15:0]      pc_m2;
   logic [IDX_W-1:0] wb_idx;
   logic [IDX_W:0]   head;
   logic [IDX_W-1:0] head_idx;
   logic             head_taken;
   logic             push, pop, full, empty;
   logic             unused_pc_bits;

   // Word-aligned index of the branch itself (PC+2 minus 2, modulo 2**16).
   assign pc_m2          = bus.wb_pcplus2 - PC_STEP;
   assign wb_idx         = pc_m2[IDX_W:1];
   assign unused_pc_bits = ^{pc_m2[15:IDX_W+1], pc_m2[0]};

   assign head_idx   = head[IDX_W:1];
   assign head_taken = head[0];

   // The sweep overwrites everything, so arrivals during INIT are simply ignored.
   assign push = bus.wb_valid && (state_q != INIT);
   assign pop  = (state_q == READ) && !bus.flush_req;

   bp_update_fifo #(
      .DEPTH(DEPTH),
      .WIDTH(IDX_W + 1)
   ) u_fifo (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .pop  (pop),
      .clear(bus.flush_req),
      .din  ({wb_idx, bus.wb_taken}),
      .head (head),
      .full (full),
      .empty(empty)
   );

   always_comb begin
      state_d   = state_q;
      sweep_d   = sweep_q;
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
      we_d      = 1'b0;
      if (bus.flush_req) begin
         state_d = INIT;
         sweep_d = '0;
      end else begin
         case (state_q)
            INIT: begin
               we_d      = 1'b1;
               wr_idx_d  = sweep_q;
               wr_data_d = INIT_STATE;
               sweep_d   = sweep_q + SWEEP_ONE;
               if (sweep_q == LAST_IDX) state_d = IDLE;
            end
            IDLE: begin
               if (!empty) state_d = READ;
            end
            READ: begin
               we_d      = 1'b1;
               wr_idx_d  = head_idx;
               wr_data_d = sat_next(bus.pht_rd_data, head_taken);
               state_d   = WRITE;
            end
            WRITE: begin
               state_d = empty ? IDLE : READ;
            end
            default: state_d = INIT;
         endcase
      end
      busy_d = (state_d == INIT);
      ovf_d  = push && full && !pop && !bus.flush_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= INIT;
         sweep_q   <= '0;
         wr_idx_q  <= '0;
         wr_data_q <= INIT_STATE;
         we_q      <= 1'b0;
         busy_q    <= 1'b1;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sweep_q   <= sweep_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         we_q      <= we_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
      end
   end

   // A flush arriving in WRITE must still cancel the already-staged write.
   assign bus.pht_we       = we_q && !bus.flush_req;
   assign bus.pht_wr_index = wr_idx_q;
   assign bus.pht_wr_data  = wr_data_q;
   assign bus.pht_rd_index = (state_q == READ) ? head_idx : '0;
   assign bus.init_busy    = busy_q;
   assign bus.q_full       = full;
   assign bus.q_overflow   = ovf_q;

`ifdef BP_STATS_EN
   logic [31:0] stat_br_q, stat_br_d;
   logic [31:0] stat_mis_q, stat_mis_d;

   always_comb begin
      stat_br_d  = stat_br_q;
      stat_mis_d = stat_mis_q;
      if (bus.wb_valid) begin
         stat_br_d = stat_br_q + 32'd1;
         if (bus.wb_pred_taken != bus.wb_taken) stat_mis_d = stat_mis_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_br_q  <= '0;
         stat_mis_q <= '0;
      end else begin
         stat_br_q  <= stat_br_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   assign bus.stat_branches    = stat_br_q;
   assign bus.stat_mispredicts = stat_mis_q;
`else
   logic unused_pred_taken;
   assign unused_pred_taken = bus.wb_pred_taken;
`endif

endmodule

// File: doc/bp_update_sched.md
Name: bp_update_sched

Overview:
- Sequences all writes into the 256-entry, 2-bit branch pattern history table (PHT).
- Buffers resolved branches arriving from WB in a small FIFO and performs a serialized read-modify-write of each saturating counter.
- Owns table initialization after reset and on flush request by sweeping every entry to weakly-not-taken.
- Sits between the WB stage and the PHT's second (update) port; the IF-side read port is untouched.

Parameters:
- DEPTH, 4, FIFO entries of pending updates; power of two, 2..16.
- IDX_W, 8, PHT index width; the table has 2**IDX_W entries.
- INIT_STATE, 2'b01, counter value written during the init sweep.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wb_valid  in  1  a resolved branch is in WB this cycle
- wb_pcplus2  in  16  PC+2 of the WB branch (lc3b_word)
- wb_taken  in  1  actual branch outcome
- wb_pred_taken  in  1  prediction made at fetch; used only under the optional feature
- flush_req  in  1  single-cycle pulse requesting a table re-initialization
- pht_rd_index  out  IDX_W  update-port read index
- pht_rd_data  in  2  counter value at pht_rd_index, combinational, same cycle
- pht_we  out  1  PHT write enable
- pht_wr_index  out  IDX_W  write index
- pht_wr_data  out  2  write data
- init_busy  out  1  init sweep in progress
- q_full  out  1  FIFO full
- q_overflow  out  1  one-cycle pulse when an update is dropped

Behaviour:
- Reset values: pht_we=0, pht_wr_index=0, pht_wr_data=INIT_STATE, pht_rd_index=0, q_full=0, q_overflow=0, init_busy=1.
- After reset the FSM is in INIT and the FIFO is empty.
- Index derivation: idx = (wb_pcplus2 - 16'h2)[IDX_W:1], i.e. word-aligned bits above bit 0. Subtraction is 16-bit modulo: pcplus2=0 gives idx from 16'hFFFE.
- Enqueue rule: on wb_valid with FIFO not full, push {idx, wb_taken}. In every state except INIT the push is accepted.
- In INIT, pushes are discarded silently with no overflow pulse, because the sweep would overwrite them.
- Overflow: wb_valid with FIFO full drops the update and pulses q_overflow for one cycle.
- Simultaneous push and pop when full: the pop happens first, so the push is accepted.
- FSM states: INIT, IDLE, READ, WRITE.
- INIT:
  - Each cycle: pht_we=1, pht_wr_index=sweep counter, pht_wr_data=INIT_STATE; the counter increments.
  - After index 2**IDX_W-1 is written: go to IDLE, init_busy=0 on the following cycle.
  - The sweep takes exactly 2**IDX_W cycles; FIFO contents are cleared on entry.
- IDLE: if the FIFO is non-empty, go to READ. The head is not popped yet.
- READ:
  - pht_rd_index = head index; capture pht_rd_data into a register.
  - Compute next value:
    - taken: saturating increment, 11 holds.
    - not taken: saturating decrement, 00 holds.
  - Pop the head and go to WRITE.
- WRITE:
  - pht_we=1 for one cycle with the registered index and next value.
  - Go to READ if the FIFO is non-empty, else IDLE.
  - Each update therefore costs 2 cycles; pht_we is asserted only in INIT and WRITE.
- Same-index back-to-back updates: the WRITE of entry n completes before the READ of entry n+1. No forwarding is needed; the PHT write is visible to the next-cycle read.
- flush_req in any state:
  - Abort any in-flight update (no write is issued).
  - Clear the FIFO, reset the sweep counter to 0, enter INIT, init_busy=1 the next cycle.
  - flush_req during INIT restarts the sweep from 0.
- Reset mid-operation forces the reset values immediately, regardless of state.

Optional Feature:
- BP_STATS_EN defined:
  - Adds outputs stat_branches (32) and stat_mispredicts (32).
  - On each accepted or dropped wb_valid, stat_branches increments; stat_mispredicts increments when wb_pred_taken != wb_taken.
  - Both counters wrap modulo 2**32, clear on reset, and are not cleared by flush_req.
- BP_STATS_EN undefined: no counters or ports exist; wb_pred_taken is unused.

Decomposition:
- lc3b_types gains:
  - bp_state_t enum (INIT, IDLE, READ, WRITE);
  - pht_cnt_t (2-bit);
  - the PHT_INIT constant 2'b01;
  - the sat_next(cnt, taken) function, shared with pht_update_ctrl.
- One sub-module, bp_update_fifo: parameterized DEPTH x (IDX_W+1) synchronous FIFO with push, pop, clear, full, empty, and head.

Test Plan:
- Reset released -> init_busy high 256 cycles, pht_we=1 writing 01 to indices 0..255 in order, then init_busy=0, pht_we=0.
- After init, one branch wb_pcplus2=16'h3008 taken, table entry=01 -> READ rd_index=0x03, next cycle write index 0x03 data 10.
- Same PC taken four times with entry at 10 -> writes 11, 11, 11, 11 (saturation); not taken from 00 -> writes 00.
- Five wb_valid pulses on consecutive cycles, DEPTH=4, drain stalled by an in-flight update -> q_full asserts and q_overflow pulses exactly once; four writes follow at 2-cycle spacing.
- flush_req during WRITE with 3 queued -> no write from that entry, FIFO empty, full 256-cycle sweep restarts at index 0.
- With BP_STATS_EN: 10 branches, 3 with pred != actual -> stat_branches=10, stat_mispredicts=3; flush_req leaves both unchanged.
